// File: rtl/cex_scanner_pkg.sv
// Shared definitions for the counterexample scanner: default assignment
// width and the controller state encoding.
package cex_scanner_pkg;

    // Number of checker input bits driven by the scanner.
    localparam int CEX_WIDTH = 31;

    // Controller states; the fourth encoding of the 2-bit field is illegal
    // and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_e;

endpackage : cex_scanner_pkg

// File: rtl/cex_scanner_if.sv
// Bundle of the scanner's control, checker and result signals. The slave
// modport is the scanner itself; the master modport is its environment
// (host issuing scans, external checker and result consumer).
interface cex_scanner_if
    import cex_scanner_pkg::*;
#(
    parameter int WIDTH = CEX_WIDTH
);

    // Scan control from the host.
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] limit;

    // Downstream combinational checker loop.
    logic [WIDTH-1:0] assign_o;
    logic             check_i;

    // Status and result handshake.
    logic             busy;
    logic             res_valid;
    logic             res_ready;
    logic             found;
    logic             aborted;
    logic [WIDTH-1:0] cex;
    logic [WIDTH:0]   evals;

    modport slave (
        input  start, abort, base, limit, check_i, res_ready,
        output assign_o, busy, res_valid, found, aborted, cex, evals
    );

    modport master (
        output start, abort, base, limit, check_i, res_ready,
        input  assign_o, busy, res_valid, found, aborted, cex, evals
    );

endinterface : cex_scanner_if

// File: rtl/cex_scanner.sv
// Exhaustive counterexample scanner. Walks assignments base..limit
// (inclusive, wrapping modulo 2^WIDTH) through an external combinational
// checker, one per cycle, and reports the first falsifying assignment, an
// abort, or a clean pass together with the number of assignments evaluated.
// WIDTH must match the WIDTH of the connected interface instance.
module cex_scanner
    import cex_scanner_pkg::*;
#(
    parameter int WIDTH = CEX_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    cex_scanner_if.slave  bus
);

    state_e           state_q;
    logic [WIDTH-1:0] cur_q;
    logic [WIDTH-1:0] lim_q;
    logic [WIDTH:0]   evals_q;
    logic [WIDTH-1:0] cex_q;
    logic             found_q;
    logic             aborted_q;
    logic             busy_q;
    logic             res_valid_q;

    // Next assignment; all-ones rolls over to zero so wrapped ranges work.
    logic [WIDTH-1:0] cur_d;
    assign cur_d = cur_q + WIDTH'(1);

    // Controller and datapath: one registered FSM so every output is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register, datapath included, is cleared by reset because
        // the result ports must read zero while rst_n is low; there is no
        // memory array here that would make a full reset expensive.
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            lim_q       <= '0;
            evals_q     <= '0;
            cex_q       <= '0;
            found_q     <= 1'b0;
            aborted_q   <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments only, so every branch below reads
            // the pre-edge value of each register regardless of statement order.
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        cur_q     <= bus.base;
                        lim_q     <= bus.limit;
                        evals_q   <= '0;
                        cex_q     <= '0;
                        found_q   <= 1'b0;
                        aborted_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= SCAN;
                    end
                end

                SCAN: begin
                    // The assignment on assign_o this cycle always counts,
                    // whatever the outcome.
                    evals_q <= evals_q + (WIDTH + 1)'(1);
                    if (!bus.check_i) begin
                        // A falsifier outranks a simultaneous abort.
                        cex_q       <= cur_q;
                        found_q     <= 1'b1;
                        res_valid_q <= 1'b1;
                        state_q     <= REPORT;
                    end else if (bus.abort) begin
                        aborted_q   <= 1'b1;
                        found_q     <= 1'b0;
                        res_valid_q <= 1'b1;
                        state_q     <= REPORT;
                    end else if (cur_q == lim_q) begin
                        found_q     <= 1'b0;
                        res_valid_q <= 1'b1;
                        state_q     <= REPORT;
                    end else begin
                        cur_q <= cur_d;
                    end
                end

                REPORT: begin
                    // Result registers are left untouched so they remain
                    // readable until the next accepted start.
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.assign_o  = cur_q;
    assign bus.busy      = busy_q;
    assign bus.res_valid = res_valid_q;
    assign bus.found     = found_q;
    assign bus.aborted   = aborted_q;
    assign bus.cex       = cex_q;
    assign bus.evals     = evals_q;

endmodule : cex_scanner

// File: tb/tb_cex_scanner.sv
// Self-checking bench for cex_scanner. A stub checker falsifies any
// assignment found in a small programmable set; a reference model predicts
// each scan's result, which is queued at start and compared when the
// scanner raises res_valid.
module tb_cex_scanner;
    import cex_scanner_pkg::*;

    localparam int W = CEX_WIDTH;
    typedef logic [W-1:0] word_t;
    typedef struct packed {
        logic         found;
        logic         aborted;
        word_t        cex;
        logic [W:0]   evals;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    cex_scanner_if #(.WIDTH(W)) bus ();

    cex_scanner #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Stub checker: property fails exactly on the enabled set members.
    word_t fal_val [4];
    logic  fal_en  [4];
    always_comb begin
        bus.check_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (fal_en[i] && (bus.assign_o == fal_val[i])) bus.check_i = 1'b0;
        end
    end

    res_t  sb [$];
    word_t seen_q [$];
    int    n_cmp = 0;
    int    n_bad = 0;

    function automatic string fmt(input res_t r);
        return $sformatf("found=%0b aborted=%0b cex=0x%h evals=%0d",
                         r.found, r.aborted, r.cex, r.evals);
    endfunction

    // Reference model: walk the range the way the scanner should.
    function automatic res_t predict(input word_t b, input word_t l, input int abort_at);
        res_t  r;
        word_t cur;
        int    n;
        r   = '0;
        cur = b;
        n   = 0;
        while (n < 100000) begin
            n++;
            for (int i = 0; i < 4; i++) begin
                if (fal_en[i] && (cur == fal_val[i])) begin
                    r.found = 1'b1;
                    r.cex   = cur;
                    r.evals = n[W:0];
                    return r;
                end
            end
            if (n == abort_at) begin
                r.aborted = 1'b1;
                r.evals   = n[W:0];
                return r;
            end
            if (cur == l) begin
                r.evals = n[W:0];
                return r;
            end
            cur = cur + word_t'(1);
        end
        return r;
    endfunction

    task automatic clear_fal();
        for (int i = 0; i < 4; i++) begin
            fal_en[i]  = 1'b0;
            fal_val[i] = '0;
        end
    endtask

    task automatic set_fal(input int idx, input word_t v);
        fal_val[idx] = v;
        fal_en[idx]  = 1'b1;
    endtask

    // Queue the prediction, pulse start; returns at the negedge of SCAN cycle 1.
    task automatic start_scan(input word_t b, input word_t l, input int abort_at);
        sb.push_back(predict(b, l, abort_at));
        @(negedge clk);
        bus.start = 1'b1;
        bus.base  = b;
        bus.limit = l;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Sample once per negedge until res_valid; records the SCAN sequence and
    // the sample taken just before the result appeared.
    task automatic collect(input int budget, output res_t got, output bit ok,
                           output word_t last_a, output logic last_rv);
        ok      = 1'b0;
        got     = '0;
        last_a  = '0;
        last_rv = 1'b0;
        seen_q.delete();
        for (int c = 0; c < budget; c++) begin
            if (bus.res_valid) begin
                got = {bus.found, bus.aborted, bus.cex, bus.evals};
                ok  = 1'b1;
                break;
            end
            if (bus.busy) seen_q.push_back(bus.assign_o);
            last_a  = bus.assign_o;
            last_rv = bus.res_valid;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({bus.assign_o, bus.busy, bus.res_valid} !== '0) begin
            n_bad++;
            $display("FAIL reset_ctrl: assign_o=0x%h busy=%0b res_valid=%0b, expected all 0",
                     bus.assign_o, bus.busy, bus.res_valid);
        end
        n_cmp++;
        if ({bus.found, bus.aborted, bus.cex, bus.evals} !== '0) begin
            n_bad++;
            $display("FAIL reset_result: got %s, expected all 0",
                     fmt({bus.found, bus.aborted, bus.cex, bus.evals}));
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.res_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_release: busy=%0b res_valid=%0b, expected 0 0",
                     bus.busy, bus.res_valid);
        end
    endtask

    task automatic test_falsify();
        res_t got, exp;
        bit ok;
        word_t la;
        logic lrv;
        clear_fal();
        set_fal(0, 31'h105);
        bus.res_ready = 1'b1;
        start_scan(31'h100, 31'h1FF, 0);
        collect(50, got, ok, la, lrv);
        exp = sb.pop_front();
        n_cmp++;
        if (!ok || got !== exp) begin
            n_bad++;
            $display("FAIL falsify_result: got %s (valid=%0b), expected %s", fmt(got), ok, fmt(exp));
        end
        n_cmp++;
        if (!(la == 31'h105 && lrv == 1'b0)) begin
            n_bad++;
            $display("FAIL falsify_latency: prior cycle assign_o=0x%h res_valid=%0b, expected 0x105 0",
                     la, lrv);
        end
        @(negedge clk);
        n_cmp++;
        if ({bus.res_valid, bus.busy, bus.found, bus.cex} !== {1'b0, 1'b0, 1'b1, 31'h105}) begin
            n_bad++;
            $display("FAIL falsify_accept: res_valid=%0b busy=%0b found=%0b cex=0x%h, expected 0 0 1 0x105",
                     bus.res_valid, bus.busy, bus.found, bus.cex);
        end
    endtask

    task automatic test_no_falsify();
        res_t got, exp;
        bit ok, seq_ok;
        word_t la;
        logic lrv;
        word_t exp_seq [$];
        clear_fal();
        exp_seq = '{31'h10, 31'h11, 31'h12, 31'h13};
        start_scan(31'h10, 31'h13, 0);
        collect(50, got, ok, la, lrv);
        exp = sb.pop_front();
        n_cmp++;
        if (!ok || got !== exp) begin
            n_bad++;
            $display("FAIL pass_result: got %s (valid=%0b), expected %s", fmt(got), ok, fmt(exp));
        end
        seq_ok = (seen_q.size() == exp_seq.size());
        for (int i = 0; i < seen_q.size() && seq_ok; i++) if (seen_q[i] !== exp_seq[i]) seq_ok = 1'b0;
        n_cmp++;
        if (!seq_ok) begin
            n_bad++;
            $display("FAIL pass_sequence: got %p, expected %p", seen_q, exp_seq);
        end
        @(negedge clk);
    endtask

    task automatic test_single();
        res_t got, exp;
        bit ok;
        word_t la;
        logic lrv;
        clear_fal();
        start_scan(31'h55, 31'h55, 0);
        collect(20, got, ok, la, lrv);
        exp = sb.pop_front();
        n_cmp++;
        if (!ok || got !== exp) begin
            n_bad++;
            $display("FAIL single_result: got %s (valid=%0b), expected %s", fmt(got), ok, fmt(exp));
        end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        res_t got, exp;
        bit ok, seq_ok;
        word_t la;
        logic lrv;
        word_t exp_seq [$];
        clear_fal();
        set_fal(0, 31'h0);
        exp_seq = '{31'h7FFFFFFE, 31'h7FFFFFFF, 31'h0};
        start_scan(31'h7FFFFFFE, 31'h1, 0);
        collect(20, got, ok, la, lrv);
        exp = sb.pop_front();
        n_cmp++;
        if (!ok || got !== exp) begin
            n_bad++;
            $display("FAIL wrap_result: got %s (valid=%0b), expected %s", fmt(got), ok, fmt(exp));
        end
        seq_ok = (seen_q.size() == exp_seq.size());
        for (int i = 0; i < seen_q.size() && seq_ok; i++) if (seen_q[i] !== exp_seq[i]) seq_ok = 1'b0;
        n_cmp++;
        if (!seq_ok) begin
            n_bad++;
            $display("FAIL wrap_sequence: got %p, expected %p", seen_q, exp_seq);
        end
        @(negedge clk);
        // Wrapped range with no falsifier: 2^W - base + limit + 1 evaluations.
        clear_fal();
        start_scan(31'h7FFFFFFD, 31'h2, 0);
        collect(20, got, ok, la, lrv);
        exp = sb.pop_front();
        n_cmp++;
        if (!ok || got !== exp) begin
            n_bad++;
            $display("FAIL wrap_count: got %s (valid=%0b), expected %s", fmt(got), ok, fmt(exp));
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        res_t got, exp;
        bit ok;
        word_t la;
        logic lrv;
        for (int pass = 0; pass < 2; pass++) begin
            clear_fal();
            // Second pass puts a falsifier on the abort cycle (cur = 9).
            if (pass == 1) set_fal(0, 31'h9);
            start_scan(31'h0, 31'hFF, 10);
            fork
                collect(100, got, ok, la, lrv);
                begin
                    repeat (9) @(negedge clk);
                    bus.abort = 1'b1;
                    @(negedge clk);
                    bus.abort = 1'b0;
                end
            join
            exp = sb.pop_front();
            n_cmp++;
            if (!ok || got !== exp) begin
                n_bad++;
                $display("FAIL abort_result_%0d: got %s (valid=%0b), expected %s",
                         pass, fmt(got), ok, fmt(exp));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_hold();
        res_t got, exp, now;
        bit ok, stable;
        word_t la;
        logic lrv;
        clear_fal();
        set_fal(0, 31'h22);
        bus.res_ready = 1'b0;
        start_scan(31'h20, 31'h30, 0);
        collect(30, got, ok, la, lrv);
        exp = sb.pop_front();
        n_cmp++;
        if (!ok || got !== exp) begin
            n_bad++;
            $display("FAIL hold_result: got %s (valid=%0b), expected %s", fmt(got), ok, fmt(exp));
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus.start = 1'b1;
                bus.base  = 31'h0;
                bus.limit = 31'h5;
            end
            if (i == 2) bus.start = 1'b0;
            now    = {bus.found, bus.aborted, bus.cex, bus.evals};
            stable = bus.res_valid && (now === exp);
            n_cmp++;
            if (!stable) begin
                n_bad++;
                $display("FAIL hold_stable_%0d: res_valid=%0b %s, expected res_valid=1 %s",
                         i, bus.res_valid, fmt(now), fmt(exp));
            end
        end
        n_cmp++;
        if ({bus.busy, bus.assign_o} !== {1'b1, 31'h22}) begin
            n_bad++;
            $display("FAIL hold_assign: busy=%0b assign_o=0x%h, expected 1 0x22", bus.busy, bus.assign_o);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus.res_valid, bus.busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL hold_release: res_valid=%0b busy=%0b, expected 0 0", bus.res_valid, bus.busy);
        end
        // Abort while idle must not disturb anything.
        bus.abort = 1'b1;
        repeat (3) @(negedge clk);
        now = {bus.found, bus.aborted, bus.cex, bus.evals};
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || now !== exp) begin
            n_bad++;
            $display("FAIL idle_abort: busy=%0b res_valid=%0b %s, expected 0 0 %s",
                     bus.busy, bus.res_valid, fmt(now), fmt(exp));
        end
        bus.abort = 1'b0;
    endtask

    task automatic test_reset_mid();
        res_t got, exp;
        bit ok, quiet;
        word_t la;
        logic lrv;
        clear_fal();
        start_scan(31'h0, 31'hFFFF, 0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        n_cmp++;
        if ({bus.assign_o, bus.busy, bus.res_valid, bus.found, bus.aborted, bus.cex, bus.evals} !== '0) begin
            n_bad++;
            $display("FAIL midscan_reset: assign_o=0x%h busy=%0b res_valid=%0b %s, expected all 0",
                     bus.assign_o, bus.busy, bus.res_valid,
                     fmt({bus.found, bus.aborted, bus.cex, bus.evals}));
        end
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.res_valid || bus.busy) quiet = 1'b0;
        end
        n_cmp++;
        if (!quiet) begin
            n_bad++;
            $display("FAIL midscan_quiet: res_valid or busy seen after release, expected neither");
        end
        set_fal(0, 31'h4);
        start_scan(31'h3, 31'h5, 0);
        collect(20, got, ok, la, lrv);
        exp = sb.pop_front();
        n_cmp++;
        if (!ok || got !== exp) begin
            n_bad++;
            $display("FAIL post_reset_result: got %s (valid=%0b), expected %s", fmt(got), ok, fmt(exp));
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.base      = '0;
        bus.limit     = '0;
        bus.res_ready = 1'b0;
        clear_fal();
        test_reset();
        test_falsify();
        test_no_falsify();
        test_single();
        test_wrap();
        test_abort();
        test_hold();
        test_reset_mid();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_cex_scanner
